// File: rtl/meta_pkt_gen_if.sv
// Valid/ready packet stream carrying one beat per handshake plus
// per-packet sideband (sop/eop, src/dst port).
interface meta_pkt_gen_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_src;
  logic [1:0]  out_dst;

  modport master (
    output out_valid, out_data, out_sop, out_eop, out_src, out_dst,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_sop, out_eop, out_src, out_dst,
    output out_ready
  );
endinterface

// File: rtl/meta_pkt_gen.sv
// Metadata FIFO feeding a packet generator: each queued metadata word becomes a
// header beat followed by len-1 payload beats on the stream interface.
module meta_pkt_gen #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  meta_en,
  input  logic [31:0]           meta_in,
  input  logic [31:0]           ctrl,
  meta_pkt_gen_if.master        strm,
  output logic [CW-1:0]         fifo_count,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic [15:0]           pkt_count,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     pkt_q, pkt_d;
  logic [15:0]     tag_q, tag_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      src_q, src_d;
  logic [1:0]      dst_q, dst_d;

  logic            enable, flush, push, pop, hs, full;
  logic [31:0]     head;
  logic [7:0]      head_len;
  logic [7:0]      idx_nxt;
  logic            ctrl_unused;

  assign enable      = ctrl[0];
  assign flush       = ctrl[1];
  assign ctrl_unused = ^ctrl[31:2];

  // Fullness comes from the registered count, so a same-cycle pop never rescues a push.
  assign full     = (count_q == CW'(DEPTH));
  assign push     = meta_en && !full && !flush;
  assign pop      = (state_q == IDLE) && enable && (count_q != '0) && !flush;
  assign hs       = valid_q && strm.out_ready;
  assign head     = mem_q[rd_ptr_q];
  assign head_len = (head[15:8] == 8'd0) ? 8'd1 : head[15:8];
  assign idx_nxt  = idx_q + 8'd1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      if (meta_en && full) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    tag_d   = tag_q;
    len_d   = len_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    data_d  = data_q;
    src_d   = src_q;
    dst_d   = dst_q;
    if (flush) begin
      state_d = IDLE;
      pkt_d   = '0;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_d = HDR;
            tag_d   = head[31:16];
            len_d   = head_len;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (head_len == 8'd1);
            data_d  = head;
            src_d   = head[3:2];
            dst_d   = head[1:0];
          end
        end
        HDR: begin
          if (hs) begin
            if (len_q == 8'd1) begin
              state_d = IDLE;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              pkt_d   = pkt_q + 16'd1;
            end else begin
              state_d = PAY;
              idx_d   = 8'd1;
              sop_d   = 1'b0;
              data_d  = {tag_q, 8'h00, 8'd1};
              eop_d   = (len_q == 8'd2);
            end
          end
        end
        PAY: begin
          if (hs) begin
            if (eop_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              eop_d   = 1'b0;
              pkt_d   = pkt_q + 16'd1;
            end else begin
              idx_d  = idx_nxt;
              data_d = {tag_q, 8'h00, idx_nxt};
              eop_d  = (idx_nxt == len_q - 8'd1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= meta_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      pkt_q    <= '0;
      tag_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      pkt_q    <= pkt_d;
      tag_q    <= tag_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      data_q   <= data_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
    end
  end

  assign strm.out_valid = valid_q;
  assign strm.out_sop   = sop_q;
  assign strm.out_eop   = eop_q;
  assign strm.out_data  = data_q;
  assign strm.out_src   = src_q;
  assign strm.out_dst   = dst_q;
  assign fifo_count     = count_q;
  assign fifo_full      = full;
  assign overflow       = ovf_q;
  assign pkt_count      = pkt_q;
  assign busy           = (state_q != IDLE);

endmodule
